// File: rtl/enroll_pkg.sv
// Shared definitions for the credential enrollment write path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package enroll_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 5;
    localparam int NIB_W  = 4;

    // ID 0 marks an empty slot in the store, so it can never be enrolled.
    localparam logic [ID_W-1:0] RESERVED_ID = 4'h0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ID,
        S_GET_PWD,
        S_GET_CONF,
        S_CHECK,
        S_WRITE,
        S_DONE,
        S_FAIL
    } state_t;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level input is high.
// Latency: pulse is combinational in the cycle the input rises; history is registered.
// Backpressure: none; a held input yields exactly one pulse.
// Ports: clk, reset (sync, active-high), sig_lvl (level input), pulse (rising-edge strobe).
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic sig_lvl,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_lvl;
        end
    end

    assign pulse = sig_lvl & ~sig_q;

endmodule

// File: rtl/credential_enroll_writer.sv
// Collects an ID plus a double-entered password from buttons and writes one store record on match.
// Latency: last confirm press cycle N -> CHECK N+1 -> wr_en N+2 -> Green_LED N+3.
// Backpressure: none; the store write port is assumed always ready, presses outside entry states are dropped.
// Ports: clk/reset; Enroll_start, data_in, data_BS, Abort_signal (operator inputs);
//        wr_en/wr_addr/wr_id/wr_pwd (store write port); SevSeg_digit, Green_LED, Red_LED,
//        Busy, Full, entry_count (status).
module credential_enroll_writer
    import enroll_pkg::*;
#(
    parameter int PWD_DIGITS  = 4,
    parameter int MAX_ENTRIES = 32,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Enroll_start,
    input  logic [NIB_W-1:0]       data_in,
    input  logic                   data_BS,
    input  logic                   Abort_signal,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [ID_W-1:0]        wr_id,
    output logic [4*NIB_W-1:0]     wr_pwd,
    output logic [NIB_W-1:0]       SevSeg_digit,
    output logic                   Green_LED,
    output logic                   Red_LED,
    output logic                   Busy,
    output logic                   Full,
    output logic [5:0]             entry_count
);

    localparam logic [1:0]  LAST_DIGIT = 2'(PWD_DIGITS - 1);
    localparam logic [31:0] HOLD_LOAD  = 32'(HOLD_CYCLES - 1);

    state_t              state, next_state;
    logic                press, start;
    logic                accept, do_abort, last_digit, full;
    logic [ID_W-1:0]     id_q;
    logic [4*NIB_W-1:0]  pwd_a, pwd_b;
    logic [1:0]          digit;
    logic [31:0]         hold_cnt;
    logic [NIB_W-1:0]    sev_q;

    edge_pulse u_bs_edge (
        .clk     (clk),
        .reset   (reset),
        .sig_lvl (data_BS),
        .pulse   (press)
    );

    edge_pulse u_start_edge (
        .clk     (clk),
        .reset   (reset),
        .sig_lvl (Enroll_start),
        .pulse   (start)
    );

    assign full       = (entry_count == 6'(MAX_ENTRIES));
    assign last_digit = (digit == LAST_DIGIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort takes priority over a press in the same cycle, so a nibble
    // arriving alongside an abort is never accepted.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        do_abort   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = full ? S_FAIL : S_GET_ID;
            end
            S_GET_ID: begin
                if (Abort_signal) begin
                    do_abort   = 1'b1;
                    next_state = S_IDLE;
                end else if (press) begin
                    accept     = 1'b1;
                    next_state = (data_in == RESERVED_ID) ? S_FAIL : S_GET_PWD;
                end
            end
            S_GET_PWD: begin
                if (Abort_signal) begin
                    do_abort   = 1'b1;
                    next_state = S_IDLE;
                end else if (press) begin
                    accept = 1'b1;
                    if (last_digit) next_state = S_GET_CONF;
                end
            end
            S_GET_CONF: begin
                if (Abort_signal) begin
                    do_abort   = 1'b1;
                    next_state = S_IDLE;
                end else if (press) begin
                    accept = 1'b1;
                    if (last_digit) next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (Abort_signal) begin
                    do_abort   = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    // The full guard is redundant with the IDLE check but keeps
                    // the "never write while full" property local to the write.
                    next_state = ((pwd_a == pwd_b) && !full) ? S_WRITE : S_FAIL;
                end
            end
            S_WRITE: next_state = S_DONE;
            S_DONE, S_FAIL: begin
                if (hold_cnt == 32'd0) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_q        <= '0;
            pwd_a       <= '0;
            pwd_b       <= '0;
            digit       <= '0;
            sev_q       <= '0;
            hold_cnt    <= '0;
            wr_addr     <= '0;
            wr_id       <= '0;
            wr_pwd      <= '0;
            entry_count <= '0;
        end else begin
            // Buffers sit at zero while idle so unused upper password nibbles
            // are zero for PWD_DIGITS < 4 and every enrollment starts clean.
            if (state == S_IDLE || do_abort) begin
                id_q  <= '0;
                pwd_a <= '0;
                pwd_b <= '0;
                digit <= '0;
            end

            if (accept) begin
                sev_q <= data_in;
                case (state)
                    S_GET_ID: begin
                        id_q  <= data_in;
                        digit <= '0;
                    end
                    S_GET_PWD: begin
                        for (int i = 0; i < 4; i++) begin
                            if (digit == 2'(i)) pwd_a[i*NIB_W +: NIB_W] <= data_in;
                        end
                        digit <= last_digit ? 2'd0 : digit + 2'd1;
                    end
                    S_GET_CONF: begin
                        for (int i = 0; i < 4; i++) begin
                            if (digit == 2'(i)) pwd_b[i*NIB_W +: NIB_W] <= data_in;
                        end
                        digit <= last_digit ? 2'd0 : digit + 2'd1;
                    end
                    default: ;
                endcase
            end

            // Write port fields are registered on the way into WRITE so they
            // are stable for the whole wr_en cycle.
            if (state == S_CHECK && next_state == S_WRITE) begin
                wr_addr <= entry_count[ADDR_W-1:0];
                wr_id   <= id_q;
                wr_pwd  <= pwd_a;
            end

            if (state == S_WRITE && !full) begin
                entry_count <= entry_count + 6'd1;
            end

            // Load on entry to DONE/FAIL; the state is left when the count hits zero,
            // giving exactly HOLD_CYCLES cycles of LED.
            if ((next_state == S_DONE || next_state == S_FAIL) && next_state != state) begin
                hold_cnt <= HOLD_LOAD;
            end else if ((state == S_DONE || state == S_FAIL) && hold_cnt != 32'd0) begin
                hold_cnt <= hold_cnt - 32'd1;
            end else if (state != S_DONE && state != S_FAIL) begin
                hold_cnt <= '0;
            end
        end
    end

    assign wr_en        = (state == S_WRITE);
    assign Green_LED    = (state == S_DONE);
    assign Red_LED      = (state == S_FAIL);
    assign Busy         = (state != S_IDLE);
    assign Full         = full;
    assign SevSeg_digit = sev_q;

endmodule

// File: tb/tb_credential_enroll_writer.sv
// Bench for credential_enroll_writer: directed enrollments with a write-port scoreboard.
// Latency: n/a. Backpressure: n/a.
module tb_credential_enroll_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        Enroll_start;
    logic [3:0]  data_in;
    logic        data_BS;
    logic        Abort_signal;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [3:0]  wr_id;
    logic [15:0] wr_pwd;
    logic [3:0]  SevSeg_digit;
    logic        Green_LED;
    logic        Red_LED;
    logic        Busy;
    logic        Full;
    logic [5:0]  entry_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [3:0]  id;
        logic [15:0] pwd;
    } wr_t;

    wr_t exp_q[$];

    always #5 clk = ~clk;

    credential_enroll_writer #(
        .PWD_DIGITS  (4),
        .MAX_ENTRIES (2),
        .HOLD_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Enroll_start (Enroll_start),
        .data_in      (data_in),
        .data_BS      (data_BS),
        .Abort_signal (Abort_signal),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_id        (wr_id),
        .wr_pwd       (wr_pwd),
        .SevSeg_digit (SevSeg_digit),
        .Green_LED    (Green_LED),
        .Red_LED      (Red_LED),
        .Busy         (Busy),
        .Full         (Full),
        .entry_count  (entry_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-port monitor: every wr_en pulse must match the oldest expected record.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {7'd0, wr_addr, wr_id, wr_pwd}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_id",   32'(wr_id),   32'(e.id));
                chk("wr_pwd",  32'(wr_pwd),  32'(e.pwd));
            end
        end
    end

    // Each task begins with an idle cycle so successive presses are distinct
    // rising edges, and returns just after the edge that accepted the input.
    task automatic do_start();
        @(posedge clk); #1;
        Enroll_start = 1'b1;
        @(posedge clk); #1;
        Enroll_start = 1'b0;
    endtask

    task automatic press(input logic [3:0] v);
        @(posedge clk); #1;
        data_in = v;
        data_BS = 1'b1;
        @(posedge clk); #1;
        data_BS = 1'b0;
    endtask

    task automatic press_hold(input logic [3:0] v, input int n);
        @(posedge clk); #1;
        data_in = v;
        data_BS = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        data_BS = 1'b0;
    endtask

    // Presses digit 0 first; passwords are given as packed nibbles, digit 0 in [3:0].
    task automatic do_enroll(input logic [3:0] id, input logic [15:0] pa, input logic [15:0] pb);
        do_start();
        press(id);
        for (int i = 0; i < 4; i++) press(pa[i*4 +: 4]);
        for (int i = 0; i < 4; i++) press(pb[i*4 +: 4]);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Called in the CHECK cycle after the last confirm press.
    task automatic expect_ok(input string tag, input logic [5:0] count_after, input logic full_after);
        @(negedge clk);
        chk({tag, "_wr_en_check"}, 32'(wr_en), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd1);
        @(negedge clk);
        chk({tag, "_wr_en_write"}, 32'(wr_en), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "_green_hold"}, {30'd0, Green_LED, Red_LED}, 32'h2);
        end
        @(negedge clk);
        chk({tag, "_leds_off"}, {30'd0, Green_LED, Red_LED}, 32'h0);
        chk({tag, "_idle"}, 32'(Busy), 32'd0);
        chk({tag, "_count"}, 32'(entry_count), 32'(count_after));
        chk({tag, "_full"}, 32'(Full), 32'(full_after));
    endtask

    // Called in the first FAIL cycle.
    task automatic expect_red(input string tag, input logic [5:0] count_exp);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "_red_hold"}, {30'd0, Green_LED, Red_LED}, 32'h1);
            chk({tag, "_no_write"}, 32'(wr_en), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_leds_off"}, {30'd0, Green_LED, Red_LED}, 32'h0);
        chk({tag, "_idle"}, 32'(Busy), 32'd0);
        chk({tag, "_count"}, 32'(entry_count), 32'(count_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        Enroll_start = 1'b0;
        data_in      = 4'h0;
        data_BS      = 1'b0;
        Abort_signal = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("reset_outputs",
            {wr_en, Green_LED, Red_LED, Busy, Full, entry_count, SevSeg_digit},
            32'd0);
        chk("reset_wr_port", {7'd0, wr_addr, wr_id, wr_pwd}, 32'd0);

        // Presses while idle are ignored.
        press(4'hF);
        @(negedge clk);
        chk("idle_press_sevseg", 32'(SevSeg_digit), 32'd0);
        chk("idle_press_busy", 32'(Busy), 32'd0);

        // Basic enrollment: ID 5, password 1,2,3,4.
        exp_q.push_back('{addr: 5'd0, id: 4'h5, pwd: 16'h4321});
        do_enroll(4'h5, 16'h4321, 16'h4321);
        expect_ok("basic", 6'd1, 1'b0);
        chk("basic_sevseg", 32'(SevSeg_digit), 32'h4);

        // Confirmation mismatch in the last digit.
        do_enroll(4'h9, 16'h4321, 16'h5321);
        @(negedge clk);
        chk("mismatch_check_no_write", 32'(wr_en), 32'd0);
        expect_red("mismatch", 6'd1);

        // Reserved ID.
        do_start();
        press(4'h0);
        expect_red("reserved_id", 6'd1);

        do_reset();
        @(negedge clk);
        chk("reset_clears_count", 32'(entry_count), 32'd0);

        // Abort after two password digits, then a full enrollment to addr 0.
        do_start();
        press(4'h3);
        press(4'h1);
        press(4'h2);
        Abort_signal = 1'b1;
        @(posedge clk); #1;
        Abort_signal = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_leds", {30'd0, Green_LED, Red_LED}, 32'h0);
        exp_q.push_back('{addr: 5'd0, id: 4'h6, pwd: 16'h6789});
        do_enroll(4'h6, 16'h6789, 16'h6789);
        expect_ok("after_abort", 6'd1, 1'b0);

        // Held button: first digit held 10 cycles counts once; fills the store.
        exp_q.push_back('{addr: 5'd1, id: 4'h7, pwd: 16'hDCBA});
        do_start();
        press(4'h7);
        press_hold(4'hA, 10);
        press(4'hB);
        press(4'hC);
        press(4'hD);
        press(4'hA);
        press(4'hB);
        press(4'hC);
        press(4'hD);
        expect_ok("held_fill", 6'd2, 1'b1);

        // Store full: start goes straight to FAIL.
        do_start();
        expect_red("full_start", 6'd2);
        chk("full_stays", 32'(Full), 32'd1);

        // Reset during GET_CONF clears everything, including the count.
        do_reset();
        exp_q.push_back('{addr: 5'd0, id: 4'h2, pwd: 16'h1111});
        do_enroll(4'h2, 16'h1111, 16'h1111);
        expect_ok("pre_reset", 6'd1, 1'b0);
        do_start();
        press(4'h3);
        for (int i = 0; i < 4; i++) press(4'h8);
        press(4'h8);
        press(4'h8);
        @(negedge clk);
        chk("get_conf_busy", 32'(Busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_outputs",
            {wr_en, Green_LED, Red_LED, Busy, Full, entry_count, SevSeg_digit},
            32'd0);
        chk("midreset_wr_port", {7'd0, wr_addr, wr_id, wr_pwd}, 32'd0);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
